interval_mode_ctrl: RTL and testbench

INTERVAL_MODE_CTRL -- requirements
Module: interval_mode_ctrl

---
 rtl/interval_mode_ctrl_if.sv | 13 +
 rtl/interval_mode_ctrl.sv | 128 ++++++++++++
 tb/tb_interval_mode_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interval_mode_ctrl_if.sv
// Beat bus between the interval checker (master) and interval_mode_ctrl (slave):
// one valid/ready handshake carrying PARALLEL one-hot interval codes per beat.
interface interval_mode_ctrl_if #(
    parameter int PARALLEL = 2,
    parameter int INTERVAL = 8
);
    logic                               in_valid;
    logic                               in_ready;
    logic [PARALLEL-1:0][INTERVAL-1:0]  acc_interval;

    modport master (output in_valid, output acc_interval, input in_ready);
    modport slave  (input in_valid, input acc_interval, output in_ready);
endinterface

// File: rtl/interval_mode_ctrl.sv
// Per-pass histogram of one-hot interval codes with per-lane mode / max-count tracking.
// Build option: define INTERVAL_CNT_SAT_EN to saturate bin counts instead of wrapping.
module interval_mode_ctrl #(
    parameter int PARALLEL = 2,
    parameter int INTERVAL = 8,
    parameter int CNT_W    = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  j_size,
    interval_mode_ctrl_if.slave               beat,
    output logic [INTERVAL-1:0][CNT_W-1:0]    interval_cnt_o,
    output logic [PARALLEL-1:0][INTERVAL-1:0] mode_o,
    output logic [PARALLEL-1:0][CNT_W-1:0]    max_cnt_o,
    output logic [CNT_W-1:0]                  step_o,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);
    localparam int INC_W = $clog2(PARALLEL + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t                            state, state_nxt;
    logic [CNT_W-1:0]                  j_lat;
    logic                              accept;
    logic [PARALLEL-1:0][INTERVAL-1:0] code;
    logic [PARALLEL-1:0]               bad;
    logic [INTERVAL-1:0][INC_W-1:0]    bin_inc;
    logic [INTERVAL-1:0][CNT_W-1:0]    cnt_nxt;
    logic [PARALLEL-1:0][CNT_W-1:0]    cand;

    function automatic logic [CNT_W-1:0] add_cnt(input logic [CNT_W-1:0] a,
                                                 input logic [INC_W-1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(d);
`ifdef INTERVAL_CNT_SAT_EN
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
`else
        return s[CNT_W-1:0];
`endif
    endfunction

    assign accept = beat.in_valid && (state == RUN);

    // Malformed codes fold into bin 0 so every lane always contributes exactly one count.
    always_comb begin
        code    = '0;
        bad     = '0;
        bin_inc = '0;
        cnt_nxt = '0;
        cand    = '0;
        for (int p = 0; p < PARALLEL; p++) begin
            bad[p]  = !$onehot(beat.acc_interval[p]);
            code[p] = bad[p] ? INTERVAL'(1) : beat.acc_interval[p];
        end
        for (int b = 0; b < INTERVAL; b++) begin
            for (int p = 0; p < PARALLEL; p++)
                bin_inc[b] = bin_inc[b] + INC_W'(code[p][b]);
            cnt_nxt[b] = add_cnt(interval_cnt_o[b], bin_inc[b]);
        end
        for (int p = 0; p < PARALLEL; p++)
            for (int b = 0; b < INTERVAL; b++)
                if (code[p][b]) cand[p] = cnt_nxt[b];
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        beat.in_ready = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = CLEAR;
            CLEAR: begin
                busy      = 1'b1;
                state_nxt = (j_lat != '0) ? RUN : DONE;
            end
            RUN: begin
                busy          = 1'b1;
                beat.in_ready = 1'b1;
                if (accept && ((step_o + CNT_W'(1)) == j_lat)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            j_lat <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) j_lat <= j_size;
        end
    end

    // Ties keep the incumbent: only a strictly larger count moves a lane's mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval_cnt_o <= '0;
            mode_o         <= '0;
            max_cnt_o      <= '0;
            step_o         <= '0;
            err            <= 1'b0;
        end else if (state == CLEAR) begin
            interval_cnt_o <= '0;
            mode_o         <= '0;
            max_cnt_o      <= '0;
            step_o         <= '0;
            err            <= 1'b0;
        end else if (accept) begin
            interval_cnt_o <= cnt_nxt;
            step_o         <= step_o + CNT_W'(1);
            err            <= err | (|bad);
            for (int p = 0; p < PARALLEL; p++) begin
                if (cand[p] > max_cnt_o[p]) begin
                    mode_o[p]    <= code[p];
                    max_cnt_o[p] <= cand[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_interval_mode_ctrl.sv
// Scoreboard bench for interval_mode_ctrl: a behavioural model queues the expected
// end-of-pass state, which is popped and compared when done pulses.
module tb_interval_mode_ctrl;
    localparam int PARALLEL = 2;
    localparam int INTERVAL = 8;
    localparam int CNT_W    = 8;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic                              clk = 1'b0;
    logic                              rst_n = 1'b0;
    logic                              start = 1'b0;
    logic [CNT_W-1:0]                  j_size = '0;
    logic [INTERVAL-1:0][CNT_W-1:0]    interval_cnt_o;
    logic [PARALLEL-1:0][INTERVAL-1:0] mode_o;
    logic [PARALLEL-1:0][CNT_W-1:0]    max_cnt_o;
    logic [CNT_W-1:0]                  step_o;
    logic                              busy, done, err;

    interval_mode_ctrl_if #(.PARALLEL(PARALLEL), .INTERVAL(INTERVAL)) bus ();

    interval_mode_ctrl #(.PARALLEL(PARALLEL), .INTERVAL(INTERVAL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .j_size(j_size), .beat(bus),
        .interval_cnt_o(interval_cnt_o), .mode_o(mode_o), .max_cnt_o(max_cnt_o),
        .step_o(step_o), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] cnt;
        logic [15:0] mode;
        logic [15:0] maxc;
        logic [7:0]  step;
        logic        err;
    } exp_t;

    exp_t              sb[$];
    logic [7:0]        q0[$];
    logic [7:0]        q1[$];
    int                n_vec = 0;
    int                n_bad = 0;

    int                m_cnt[INTERVAL];
    int                m_max[PARALLEL];
    logic [7:0]        m_mode[PARALLEL];
    int                m_step;
    bit                m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lim(input int x);
`ifdef INTERVAL_CNT_SAT_EN
        return (x > CMAX) ? CMAX : x;
`else
        return x % (CMAX + 1);
`endif
    endfunction

    task automatic model_clear();
        foreach (m_cnt[b]) m_cnt[b] = 0;
        for (int p = 0; p < PARALLEL; p++) begin
            m_max[p]  = 0;
            m_mode[p] = '0;
        end
        m_step = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_beat(input logic [7:0] c0, input logic [7:0] c1);
        logic [7:0] c[PARALLEL];
        int         idx[PARALLEL];
        c[0] = c0;
        c[1] = c1;
        for (int p = 0; p < PARALLEL; p++) begin
            if ($countones(c[p]) != 1) begin
                c[p]  = 8'h01;
                m_err = 1'b1;
            end
            idx[p] = 0;
            for (int b = 0; b < INTERVAL; b++) if (c[p][b]) idx[p] = b;
        end
        for (int p = 0; p < PARALLEL; p++) m_cnt[idx[p]] = lim(m_cnt[idx[p]] + 1);
        for (int p = 0; p < PARALLEL; p++) begin
            if (m_cnt[idx[p]] > m_max[p]) begin
                m_max[p]  = m_cnt[idx[p]];
                m_mode[p] = c[p];
            end
        end
        m_step++;
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.cnt = '0;
        for (int b = 0; b < INTERVAL; b++) e.cnt[b*CNT_W +: CNT_W] = 8'(m_cnt[b]);
        e.mode = {m_mode[1], m_mode[0]};
        e.maxc = {8'(m_max[1]), 8'(m_max[0])};
        e.step = 8'(m_step);
        e.err  = m_err;
        return e;
    endfunction

    task automatic do_start(input int j);
        @(posedge clk); #1;
        start  = 1'b1;
        j_size = 8'(j);
        @(posedge clk); #1;
        start  = 1'b0;
        model_clear();
    endtask

    task automatic drive_beat(input logic [7:0] c0, input logic [7:0] c1);
        bit ok;
        ok = 1'b0;
        bus.in_valid     = 1'b1;
        bus.acc_interval = {c1, c0};
        for (int k = 0; k < 8 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        chk("beat_accept", 64'(ok), 64'd1);
        if (ok) model_beat(c0, c1);
    endtask

    task automatic run_pass(input int j, input bit stalls);
        exp_t e;
        do_start(j);
        for (int i = 0; i < j; i++) begin
            if (stalls && (i % 2 == 1)) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
                chk("stall_hold", 64'(step_o), 64'(m_step));
            end
            drive_beat(q0[i], q1[i]);
        end
        bus.in_valid = 1'b0;
        sb.push_back(snapshot());
        if (j == 0) begin
            @(negedge clk);
            chk("zero_clear_busy", 64'(busy), 64'd1);
            chk("zero_clear_done", 64'(done), 64'd0);
            chk("zero_ready", 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        e = sb.pop_front();
        chk("cnt", 64'(interval_cnt_o), e.cnt);
        chk("mode", 64'(mode_o), 64'(e.mode));
        chk("max_cnt", 64'(max_cnt_o), 64'(e.maxc));
        chk("step", 64'(step_o), 64'(e.step));
        chk("err", 64'(err), 64'(e.err));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic fill(input int n, input logic [7:0] a, input logic [7:0] b);
        q0.delete();
        q1.delete();
        for (int i = 0; i < n; i++) begin
            q0.push_back(a);
            q1.push_back(b);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cnt"}, 64'(interval_cnt_o), 64'd0);
        chk({tag, "_mode"}, 64'(mode_o), 64'd0);
        chk({tag, "_max"}, 64'(max_cnt_o), 64'd0);
        chk({tag, "_step"}, 64'(step_o), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        bus.in_valid     = 1'b0;
        bus.acc_interval = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Beats presented while idle must be ignored.
        bus.in_valid     = 1'b1;
        bus.acc_interval = {8'h20, 8'h04};
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", 64'(bus.in_ready), 64'd0);
        end
        chk("idle_ignore_cnt", 64'(interval_cnt_o), 64'd0);
        chk("idle_ignore_step", 64'(step_o), 64'd0);
        bus.in_valid = 1'b0;

        // lane0 bin2, lane1 bin5, four beats with stalls in between
        fill(4, 8'h04, 8'h20);
        run_pass(4, 1'b1);
        chk("p1_cnt2", 64'(interval_cnt_o[2]), 64'd4);
        chk("p1_cnt5", 64'(interval_cnt_o[5]), 64'd4);
        chk("p1_mode", 64'(mode_o), 64'h2004);
        chk("p1_max", 64'(max_cnt_o), 64'h0404);

        held = 64'(interval_cnt_o);
        bus.in_valid     = 1'b1;
        bus.acc_interval = {8'h01, 8'h01};
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("idle_hold_cnt", 64'(interval_cnt_o), held);
        chk("idle_hold_step", 64'(step_o), 64'd4);

        // both lanes bin3
        fill(3, 8'h08, 8'h08);
        run_pass(3, 1'b0);
        chk("p2_cnt3", 64'(interval_cnt_o[3]), 64'd6);
        chk("p2_max", 64'(max_cnt_o), 64'h0606);

        // ties keep the first bin to reach the max
        q0 = '{8'h02, 8'h04, 8'h02, 8'h04};
        q1 = '{8'h08, 8'h08, 8'h08, 8'h08};
        run_pass(4, 1'b0);
        chk("tie_mode0", 64'(mode_o[0]), 64'h02);
        chk("tie_max0", 64'(max_cnt_o[0]), 64'd2);

        // empty pass
        fill(0, 8'h00, 8'h00);
        run_pass(0, 1'b0);
        chk("zero_cnt", 64'(interval_cnt_o), 64'd0);

        // count overflow on bin7
        fill(200, 8'h80, 8'h80);
        run_pass(200, 1'b0);
`ifdef INTERVAL_CNT_SAT_EN
        chk("ovf_cnt7", 64'(interval_cnt_o[7]), 64'd255);
`else
        chk("ovf_cnt7", 64'(interval_cnt_o[7]), 64'd144);
`endif

        // reset in the middle of a pass
        do_start(5);
        drive_beat(8'h04, 8'h20);
        drive_beat(8'h04, 8'h20);
        chk("pre_rst_step", 64'(step_o), 64'd2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", 64'(done), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // malformed code sets err and lands in bin 0
        q0 = '{8'h02, 8'h06, 8'h02};
        q1 = '{8'h04, 8'h04, 8'h04};
        run_pass(3, 1'b0);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_cnt0", 64'(interval_cnt_o[0]), 64'd1);

        // next clean pass clears err
        fill(1, 8'h10, 8'h10);
        run_pass(1, 1'b0);
        chk("err_cleared", 64'(err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
